cp0_exception_unit: RTL and testbench

//  Parametrised coprocessor-0: holds SR/Cause/EPC/PRId/Count/Compare, arbitrates exceptions,

---
 rtl/cp0_pkg.sv | 46 ++++
 rtl/cp0_exception_unit_if.sv | 32 +++
 rtl/cp0_timer.sv | 32 +++
 rtl/cp0_exception_unit.sv | 117 +++++++++++
 tb/tb_cp0_exception_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes, field positions and pack helpers
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_BD_BIT  = 31;
    localparam int IP_W          = 6;

    localparam logic [31:0] SR_WMASK    = 32'h0000_FC03;
    localparam logic [31:0] CAUSE_RMASK = 32'h8000_FC7C;

    function automatic logic [31:0] pack_sr(logic [IP_W-1:0] im, logic exl, logic ie);
        logic [31:0] r;
        r = '0;
        r[SR_IM_LO +: IP_W] = im;
        r[SR_EXL_BIT]       = exl;
        r[SR_IE_BIT]        = ie;
        return r & SR_WMASK;
    endfunction

    function automatic logic [31:0] pack_cause(logic bd, logic [IP_W-1:0] ip, logic [4:0] exc);
        logic [31:0] r;
        r = '0;
        r[CAUSE_BD_BIT]         = bd;
        r[CAUSE_IP_LO +: IP_W]  = ip;
        r[CAUSE_EXC_LO +: 5]    = exc;
        return r & CAUSE_RMASK;
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// rtl/cp0_exception_unit_if.sv - M-stage to CP0 commit interface
interface cp0_exception_unit_if #(
    parameter int N_IRQ = 6
);
    logic             valid;
    logic             exception;
    logic [4:0]       exc_code;
    logic             bd;
    logic [31:0]      pc;
    logic             eret;
    logic             mtc0_en;
    logic [4:0]       mtc0_addr;
    logic [31:0]      mtc0_wdata;
    logic [4:0]       mfc0_addr;
    logic [N_IRQ-1:0] hw_irq;
    logic [31:0]      mfc0_rdata;
    logic             handler_req;
    logic [31:0]      epc_out;
    logic             exl_out;

    modport master (
        output valid, exception, exc_code, bd, pc, eret,
               mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr, hw_irq,
        input  mfc0_rdata, handler_req, epc_out, exl_out
    );

    modport slave (
        input  valid, exception, exc_code, bd, pc, eret,
               mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr, hw_irq,
        output mfc0_rdata, handler_req, epc_out, exl_out
    );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with sticky pending flag
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            if (count_we) count <= wdata;
            else          count <= count + 32'd1;

            // Compare==0 is treated as "timer disarmed"; rewriting Compare acknowledges.
            if (compare_we) begin
                compare    <= wdata;
                timer_pend <= 1'b0;
            end else if ((count == compare) && (compare != 32'd0)) begin
                timer_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 state, commit-stage exception/interrupt arbitration, read mux
module cp0_exception_unit
    import cp0_pkg::*;
#(
    parameter int          N_IRQ      = 6,
    parameter bit          TIMER_EN   = 1'b1,
    parameter int          TIMER_LINE = 5,
    parameter logic [31:0] PRID_VALUE = 32'h2020_0b0e
) (
    input logic                 clk,
    input logic                 reset,
    cp0_exception_unit_if.slave bus
);

    logic [IP_W-1:0] sr_im;
    logic            sr_exl;
    logic            sr_ie;
    logic            cause_bd;
    logic [IP_W-1:0] cause_ip;
    logic [4:0]      cause_exc;
    logic [31:0]     epc;

    logic [31:0]     count_q;
    logic [31:0]     compare_q;
    logic            timer_pend;

    logic [IP_W-1:0] ip_ext;
    logic [IP_W-1:0] ip_next;
    logic            irq;
    logic            submit;
    logic            eret_commit;
    logic            mtc0_commit;
    logic            count_we;
    logic            compare_we;

    always_comb begin
        ip_ext              = '0;
        ip_ext[N_IRQ-1:0]   = bus.hw_irq;
        ip_next             = ip_ext;
        ip_next[TIMER_LINE] = ip_ext[TIMER_LINE] | timer_pend;
    end

    // Interrupts look at this cycle's lines, not the registered Cause.IP.
    assign irq         = (|(ip_next & sr_im)) & sr_ie & ~sr_exl;
    assign submit      = bus.valid & ~reset & (irq | bus.exception);
    assign eret_commit = bus.valid & ~submit & bus.eret;
    assign mtc0_commit = bus.valid & ~submit & ~bus.eret & bus.mtc0_en;
    assign count_we    = mtc0_commit && (bus.mtc0_addr == REG_COUNT);
    assign compare_we  = mtc0_commit && (bus.mtc0_addr == REG_COMPARE);

    generate
        if (TIMER_EN) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .count_we   (count_we),
                .compare_we (compare_we),
                .wdata      (bus.mtc0_wdata),
                .count      (count_q),
                .compare    (compare_q),
                .timer_pend (timer_pend)
            );
        end else begin : g_no_timer
            assign count_q    = '0;
            assign compare_q  = '0;
            assign timer_pend = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= ip_next;
            if (submit) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.bd;
                cause_exc <= irq ? EXC_INT : bus.exc_code;
                epc       <= bus.bd ? (bus.pc - 32'd4) : bus.pc;
            end else if (eret_commit) begin
                sr_exl <= 1'b0;
            end else if (mtc0_commit) begin
                if (bus.mtc0_addr == REG_SR) begin
                    sr_im  <= bus.mtc0_wdata[SR_IM_LO +: IP_W];
                    sr_exl <= bus.mtc0_wdata[SR_EXL_BIT];
                    sr_ie  <= bus.mtc0_wdata[SR_IE_BIT];
                end else if (bus.mtc0_addr == REG_EPC) begin
                    epc <= {bus.mtc0_wdata[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        bus.mfc0_rdata = '0;
        case (bus.mfc0_addr)
            REG_COUNT:   bus.mfc0_rdata = count_q;
            REG_COMPARE: bus.mfc0_rdata = compare_q;
            REG_SR:      bus.mfc0_rdata = pack_sr(sr_im, sr_exl, sr_ie);
            REG_CAUSE:   bus.mfc0_rdata = pack_cause(cause_bd, cause_ip, cause_exc);
            REG_EPC:     bus.mfc0_rdata = epc;
            REG_PRID:    bus.mfc0_rdata = PRID_VALUE;
            default:     bus.mfc0_rdata = '0;
        endcase
    end

    assign bus.handler_req = submit;
    assign bus.epc_out     = epc;
    assign bus.exl_out     = sr_exl;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - directed self-checking bench for cp0_exception_unit
module tb_cp0_exception_unit;

    logic        clk;
    logic        reset;
    logic [31:0] rv;
    int          tests_run;
    int          fail_cnt;
    int          found;

    cp0_exception_unit_if #(.N_IRQ(6)) bus ();

    cp0_exception_unit #(
        .N_IRQ(6), .TIMER_EN(1'b1), .TIMER_LINE(5), .PRID_VALUE(32'h2020_0b0e)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid      = 1'b0;
        bus.exception  = 1'b0;
        bus.exc_code   = 5'd0;
        bus.bd         = 1'b0;
        bus.pc         = 32'd0;
        bus.eret       = 1'b0;
        bus.mtc0_en    = 1'b0;
        bus.mtc0_addr  = 5'd0;
        bus.mtc0_wdata = 32'd0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        bus.mfc0_addr = a;
        #1;
        v = bus.mfc0_rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        bus.valid      = 1'b1;
        bus.mtc0_en    = 1'b1;
        bus.mtc0_addr  = a;
        bus.mtc0_wdata = d;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        bus.hw_irq = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.hw_irq = '0;
        reset = 1'b1;
        bus.valid = 1'b1; bus.exception = 1'b1; bus.exc_code = 5'd4; bus.pc = 32'h100;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0) begin fail_cnt++; $display("FAIL rst_handler: got %b exp 0", bus.handler_req); end
        tick();
        rd(5'd12, rv); tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL rst_sr: got %h exp 00000000", rv); end
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL rst_cause: got %h exp 00000000", rv); end
        rd(5'd14, rv); tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL rst_epc: got %h exp 00000000", rv); end
        rd(5'd9, rv);  tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL rst_count: got %h exp 00000000", rv); end
        rd(5'd11, rv); tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL rst_compare: got %h exp 00000000", rv); end
        tests_run++; if (bus.exl_out !== 1'b0) begin fail_cnt++; $display("FAIL rst_exl: got %b exp 0", bus.exl_out); end
        reset = 1'b0;
        idle();
        rd(5'd15, rv); tests_run++; if (rv !== 32'h2020_0b0e) begin fail_cnt++; $display("FAIL prid: got %h exp 20200b0e", rv); end
        rd(5'd3, rv);  tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL unlisted_rd: got %h exp 00000000", rv); end
        // exception in flight, then reset lands on the same cycle
        bus.valid = 1'b1; bus.exception = 1'b1; bus.exc_code = 5'd5; bus.pc = 32'h200;
        #1;
        tests_run++; if (bus.handler_req !== 1'b1) begin fail_cnt++; $display("FAIL rst_pre_handler: got %b exp 1", bus.handler_req); end
        reset = 1'b1;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0) begin fail_cnt++; $display("FAIL rst_kill_handler: got %b exp 0", bus.handler_req); end
        tick();
        reset = 1'b0;
        idle();
        tests_run++; if (bus.epc_out !== 32'h0 || bus.exl_out !== 1'b0) begin fail_cnt++; $display("FAIL rst_kill_state: got epc %h exl %b exp 0/0", bus.epc_out, bus.exl_out); end
    endtask

    task automatic test_irq_basic();
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, rv); tests_run++; if (rv !== 32'h0000_0401) begin fail_cnt++; $display("FAIL t1_sr: got %h exp 00000401", rv); end
        bus.hw_irq = 6'b000001; bus.valid = 1'b1; bus.pc = 32'h0000_1000;
        #1;
        tests_run++; if (bus.handler_req !== 1'b1) begin fail_cnt++; $display("FAIL t1_handler: got %b exp 1", bus.handler_req); end
        tick();
        idle();
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0000_0400) begin fail_cnt++; $display("FAIL t1_cause: got %h exp 00000400", rv); end
        rd(5'd12, rv); tests_run++; if (rv !== 32'h0000_0403) begin fail_cnt++; $display("FAIL t1_sr_exl: got %h exp 00000403", rv); end
        tests_run++; if (bus.epc_out !== 32'h0000_1000) begin fail_cnt++; $display("FAIL t1_epc: got %h exp 00001000", bus.epc_out); end
        bus.hw_irq = '0;
    endtask

    task automatic test_exc_bd();
        idle();
        bus.valid = 1'b1; bus.exception = 1'b1; bus.exc_code = 5'd12; bus.bd = 1'b1; bus.pc = 32'h3008;
        #1;
        tests_run++; if (bus.handler_req !== 1'b1) begin fail_cnt++; $display("FAIL t2_handler: got %b exp 1", bus.handler_req); end
        tick();
        idle();
        rd(5'd14, rv); tests_run++; if (rv !== 32'h0000_3004) begin fail_cnt++; $display("FAIL t2_epc: got %h exp 00003004", rv); end
        rd(5'd13, rv); tests_run++; if (rv !== 32'h8000_0030) begin fail_cnt++; $display("FAIL t2_cause: got %h exp 80000030", rv); end
        // delay-slot fault at pc 0 wraps the EPC
        bus.valid = 1'b1; bus.exception = 1'b1; bus.exc_code = 5'd10; bus.bd = 1'b1; bus.pc = 32'h0;
        tick();
        idle();
        rd(5'd14, rv); tests_run++; if (rv !== 32'hFFFF_FFFC) begin fail_cnt++; $display("FAIL t2_epc_wrap: got %h exp fffffffc", rv); end
        rd(5'd13, rv); tests_run++; if (rv !== 32'h8000_0028) begin fail_cnt++; $display("FAIL t2_cause_ri: got %h exp 80000028", rv); end
        bus.valid = 1'b1; bus.eret = 1'b1;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0) begin fail_cnt++; $display("FAIL t2_eret_handler: got %b exp 0", bus.handler_req); end
        tick();
        idle();
        tests_run++; if (bus.exl_out !== 1'b0) begin fail_cnt++; $display("FAIL t2_eret_exl: got %b exp 0", bus.exl_out); end
        tests_run++; if (bus.epc_out !== 32'hFFFF_FFFC) begin fail_cnt++; $display("FAIL t2_eret_epc: got %h exp fffffffc", bus.epc_out); end
    endtask

    task automatic test_exl_mask();
        do_reset();
        mtc0(5'd12, 32'h0000_FC02);
        bus.hw_irq = 6'h3F; bus.valid = 1'b1;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0) begin fail_cnt++; $display("FAIL t3_exl_mask: got %b exp 0", bus.handler_req); end
        tick();
        bus.eret = 1'b1;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0) begin fail_cnt++; $display("FAIL t3_eret_mask: got %b exp 0", bus.handler_req); end
        tick();
        idle();
        bus.valid = 1'b1;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0 || bus.exl_out !== 1'b0) begin fail_cnt++; $display("FAIL t3_ie_mask: got req %b exl %b exp 0/0", bus.handler_req, bus.exl_out); end
        bus.mtc0_en = 1'b1; bus.mtc0_addr = 5'd12; bus.mtc0_wdata = 32'h0000_FC01;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0) begin fail_cnt++; $display("FAIL t3_no_bypass: got %b exp 0", bus.handler_req); end
        tick();
        idle();
        bus.valid = 1'b1;
        #1;
        tests_run++; if (bus.handler_req !== 1'b1) begin fail_cnt++; $display("FAIL t3_handler: got %b exp 1", bus.handler_req); end
        tick();
        idle();
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0000_FC00) begin fail_cnt++; $display("FAIL t3_cause: got %h exp 0000fc00", rv); end
        bus.hw_irq = '0;
    endtask

    task automatic test_timer();
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        found = -1;
        for (int i = 0; i < 20 && found < 0; i++) begin
            bus.valid = 1'b1;
            #1;
            if (bus.handler_req === 1'b1) begin
                found = i;
                rd(5'd9, rv);
            end else begin
                tick();
            end
        end
        tests_run++; if (found !== 6) begin fail_cnt++; $display("FAIL t4_fire_cycle: got %0d exp 6", found); end
        tests_run++; if (rv !== 32'd6) begin fail_cnt++; $display("FAIL t4_count_at_fire: got %h exp 00000006", rv); end
        tick();
        idle();
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0000_8000) begin fail_cnt++; $display("FAIL t4_cause_ip: got %h exp 00008000", rv); end
        mtc0(5'd11, 32'd100);
        tick();
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0000_0000) begin fail_cnt++; $display("FAIL t4_ack: got %h exp 00000000", rv); end
    endtask

    task automatic test_priority();
        do_reset();
        mtc0(5'd12, 32'h0000_0400);
        bus.valid = 1'b1; bus.exception = 1'b1; bus.exc_code = 5'd4; bus.eret = 1'b1;
        bus.mtc0_en = 1'b1; bus.mtc0_addr = 5'd12; bus.mtc0_wdata = 32'h0000_0001; bus.pc = 32'h2000;
        #1;
        tests_run++; if (bus.handler_req !== 1'b1) begin fail_cnt++; $display("FAIL t5_handler: got %b exp 1", bus.handler_req); end
        tick();
        idle();
        rd(5'd12, rv); tests_run++; if (rv !== 32'h0000_0402) begin fail_cnt++; $display("FAIL t5_sr: got %h exp 00000402", rv); end
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0000_0010) begin fail_cnt++; $display("FAIL t5_cause: got %h exp 00000010", rv); end
        tests_run++; if (bus.epc_out !== 32'h2000) begin fail_cnt++; $display("FAIL t5_epc: got %h exp 00002000", bus.epc_out); end
        bus.valid = 1'b1; bus.eret = 1'b1; bus.mtc0_en = 1'b1; bus.mtc0_addr = 5'd12; bus.mtc0_wdata = 32'h0000_FC03;
        tick();
        idle();
        rd(5'd12, rv); tests_run++; if (rv !== 32'h0000_0400) begin fail_cnt++; $display("FAIL t5_eret_over_mtc0: got %h exp 00000400", rv); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, rv); tests_run++; if (rv !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL t6_count_load: got %h exp ffffffff", rv); end
        tick();
        rd(5'd9, rv); tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL t6_count_wrap: got %h exp 00000000", rv); end
        bus.valid = 1'b0; bus.exception = 1'b1; bus.exc_code = 5'd12; bus.pc = 32'h44;
        #1;
        tests_run++; if (bus.handler_req !== 1'b0) begin fail_cnt++; $display("FAIL t6_bubble_req: got %b exp 0", bus.handler_req); end
        tick();
        idle();
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0 || bus.exl_out !== 1'b0 || bus.epc_out !== 32'h0) begin fail_cnt++; $display("FAIL t6_bubble_state: got cause %h exl %b epc %h exp 0/0/0", rv, bus.exl_out, bus.epc_out); end
        mtc0(5'd14, 32'h0000_1237);
        rd(5'd14, rv); tests_run++; if (rv !== 32'h0000_1234) begin fail_cnt++; $display("FAIL t6_epc_align: got %h exp 00001234", rv); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, rv); tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL t6_cause_ro: got %h exp 00000000", rv); end
        mtc0(5'd15, 32'h0);
        rd(5'd15, rv); tests_run++; if (rv !== 32'h2020_0b0e) begin fail_cnt++; $display("FAIL t6_prid_ro: got %h exp 20200b0e", rv); end
        mtc0(5'd3, 32'hDEAD_BEEF);
        rd(5'd3, rv); tests_run++; if (rv !== 32'h0) begin fail_cnt++; $display("FAIL t6_unlisted_wr: got %h exp 00000000", rv); end
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, rv); tests_run++; if (rv !== 32'h0000_FC03) begin fail_cnt++; $display("FAIL t6_sr_mask: got %h exp 0000fc03", rv); end
    endtask

    initial begin
        tests_run = 0;
        fail_cnt  = 0;
        rv        = '0;
        found     = -1;
        reset     = 1'b1;
        bus.mfc0_addr = 5'd0;
        bus.hw_irq    = '0;
        idle();
        tick();
        test_reset();
        test_irq_basic();
        test_exc_bd();
        test_exl_mask();
        test_timer();
        test_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
